ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
//  Per-frame ball position engine for the ping-pong game. It owns the ball centre (ball_x, ball_y),
//  which feeds the rectangle bounds stage directly. It reflects the ball off the top and bottom walls
//  and off both paddles, detects a miss past either side, and sequences serve / play / post-score pause.
// PARAMETERS
//  WIDTH          639  last visible column (x max)
//  HEIGHT         479  last visible row (y max)
//  BALL_SIZE      3    ball half-size; same value as the rectangle stage's size_x/size_y
//  PADDLE_L_X     20   left paddle centre column
//  PADDLE_R_X     619  right paddle centre column
//  PADDLE_HALF_W  3    paddle half-width
//  PADDLE_HALF_H  30   paddle half-height
//  SPEED_INIT     2    pixels per frame, per axis, after reset/score
//  SPEED_MAX      8    speed ceiling (used only with BALL_SPEEDUP_EN)
//  PAUSE_FRAMES   60   frames held at centre after a score
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  frame_tick  in   1   one-cycle pulse per frame (start of vertical blank)
//  serve       in   1   level/pulse; launches the ball from IDLE
//  paddle_l_y  in   11  left paddle centre row
//  paddle_r_y  in   11  right paddle centre row
//  ball_x      out  11  ball centre column (registered)
//  ball_y      out  11  ball centre row (registered)
//  hit         out  1   one-cycle pulse on any paddle reflection
//  score_l     out  1   one-cycle pulse: left player scores (ball exits right)
//  score_r     out  1   one-cycle pulse: right player scores (ball exits left)
//  in_play     out  1   high while the state is MOVE
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge; also valid mid-game):
//    ball_x=WIDTH/2 (319), ball_y=HEIGHT/2 (239), dx=+1, dy=+1, speed=SPEED_INIT, state=IDLE, all pulses 0.
//  - States:
//    IDLE: ball held at centre; serve=1 -> MOVE next cycle. A frame_tick in the same cycle does not move the ball.
//    MOVE: updates only in a cycle with frame_tick; outputs change 1 clk after that tick. serve is ignored.
//    PAUSE: ball at centre; counts PAUSE_FRAMES frame_ticks, then -> IDLE.
//  - Arithmetic: next positions are computed 12-bit signed, nx = x +/- speed and ny = y +/- speed,
//    so there is no unsigned wrap below 0.
//  - Y reflection:
//    ny-BALL_SIZE <= 0 -> y = BALL_SIZE, dy = +1.
//    ny+BALL_SIZE >= HEIGHT -> y = HEIGHT-BALL_SIZE, dy = -1.
//  - Left paddle, checked when dx=-1 and nx-BALL_SIZE <= PADDLE_L_X+PADDLE_HALF_W:
//    if |ball_y-paddle_l_y| <= PADDLE_HALF_H+BALL_SIZE (current y, inclusive): x = PADDLE_L_X+PADDLE_HALF_W+BALL_SIZE, dx = +1, hit=1.
//    else, once nx-BALL_SIZE <= 0: score_r=1, -> PAUSE, next serve dx = -1 (toward the loser).
//    else: x = nx (ball passes the paddle line).
//  - Right paddle mirrors the left, using PADDLE_R_X, WIDTH and score_l; next serve dx = +1.
//  - Simultaneous wall and paddle event: both axes reflect in the same frame.
//  - Score: pulse lasts exactly 1 clk; ball recentred on the same edge; speed = SPEED_INIT; dy is kept.
// CONFIGURATION
//  BALL_SPEEDUP_EN defined: each hit raises speed by 1, saturating at SPEED_MAX; a score restores SPEED_INIT.
//  BALL_SPEEDUP_EN undefined: speed is fixed at SPEED_INIT; SPEED_MAX is unused.
// STRUCTURE
//  Package pong_pkg holds:
//    - state encoding typedef (IDLE/MOVE/PAUSE)
//    - screen constants WIDTH/HEIGHT/CENTRE_X/CENTRE_Y
//    - position width (11)
//  Sub-module ball_axis_step: one-axis step plus wall clamp/reflect, instanced for y.
//  The x axis uses the same step; paddle/score logic stays in ball_motion.
// TESTING
//  1. rst, then serve=1, then 1 frame_tick -> ball_x=321, ball_y=241, in_play=1.
//  2. ball_y=238, dy=+1, speed=2, HEIGHT=479: step until ny+3>=479 -> ball_y=476, dy=-1, no hit/score.
//  3. paddle_l_y=100, ball_y=120, dx=-1, ball_x=27, speed=2 -> ball_x=26, dx=+1, hit pulse 1 clk.
//  4. paddle_l_y=300, ball_y=100, moving left -> ball passes x=26, score_r pulse at nx-3<=0,
//     ball at (319,239), PAUSE for 60 ticks, then IDLE.
//  5. BALL_SPEEDUP_EN: 7 consecutive hits -> speed 2..8, stays 8; a score returns it to 2.
//  6. rst asserted mid-MOVE with frame_tick=1 in the same cycle -> reset values win, state=IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared screen geometry, state encoding and per-axis step helpers for the pong ball engine.
// SPEED_MAX is only present when BALL_SPEEDUP_EN is defined.
package pong_pkg;

    localparam int POS_W = 11;

    typedef logic [POS_W-1:0]      pos_t;
    typedef logic signed [POS_W:0] spos_t;
    typedef logic [3:0]            speed_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam spos_t WIDTH         = 12'sd639;
    localparam spos_t HEIGHT        = 12'sd479;
    localparam spos_t BALL_SIZE     = 12'sd3;
    localparam spos_t PADDLE_L_X    = 12'sd20;
    localparam spos_t PADDLE_R_X    = 12'sd619;
    localparam spos_t PADDLE_HALF_W = 12'sd3;
    localparam spos_t PADDLE_HALF_H = 12'sd30;
    localparam spos_t SZERO         = 12'sd0;

    localparam pos_t CENTRE_X = 11'd319;
    localparam pos_t CENTRE_Y = 11'd239;

    localparam speed_t SPEED_INIT = 4'd2;
`ifdef BALL_SPEEDUP_EN
    localparam speed_t SPEED_MAX = 4'd8;
`endif

    localparam logic [5:0] PAUSE_FRAMES = 6'd60;

    // Signed step so a move below zero stays negative instead of wrapping.
    function automatic spos_t axis_step(input pos_t pos, input logic dir_pos, input speed_t speed);
        spos_t p;
        spos_t s;
        p = spos_t'({1'b0, pos});
        s = spos_t'({8'd0, speed});
        return dir_pos ? (p + s) : (p - s);
    endfunction

    function automatic logic paddle_covers(input pos_t ball, input pos_t paddle);
        spos_t d;
        d = spos_t'({1'b0, ball}) - spos_t'({1'b0, paddle});
        if (d < SZERO) begin
            d = -d;
        end
        return d <= (PADDLE_HALF_H + BALL_SIZE);
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis ball step with clamp and reflection against the two walls at 0 and LIMIT.
module ball_axis_step
    import pong_pkg::*;
#(
    parameter spos_t LIMIT = HEIGHT
) (
    input  logic [POS_W-1:0] i_pos,
    input  logic             i_dir_pos,
    input  logic [3:0]       i_speed,
    output logic [POS_W-1:0] o_pos,
    output logic             o_dir_pos
);

    spos_t w_next;

    assign w_next = axis_step(i_pos, i_dir_pos, i_speed);

    always_comb begin
        o_pos     = w_next[POS_W-1:0];
        o_dir_pos = i_dir_pos;
        if (w_next - BALL_SIZE <= SZERO) begin
            o_pos     = pos_t'(BALL_SIZE);
            o_dir_pos = 1'b1;
        end else if (w_next + BALL_SIZE >= LIMIT) begin
            o_pos     = pos_t'(LIMIT - BALL_SIZE);
            o_dir_pos = 1'b0;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball position engine: wall/paddle reflection, miss detection, serve/play/pause sequencing.
// Build option: BALL_SPEEDUP_EN adds one pixel/frame per paddle hit up to SPEED_MAX.
//   IDLE  | ball parked at centre, waiting for serve
//   MOVE  | ball advances on each frame_tick
//   PAUSE | ball parked at centre for PAUSE_FRAMES ticks after a score
module ball_motion
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        hit,
    output logic        score_l,
    output logic        score_r,
    output logic        in_play
);

    localparam spos_t L_LINE     = PADDLE_L_X + PADDLE_HALF_W;
    localparam spos_t R_LINE     = PADDLE_R_X - PADDLE_HALF_W;
    localparam pos_t  X_BOUNCE_L = pos_t'(L_LINE + BALL_SIZE);
    localparam pos_t  X_BOUNCE_R = pos_t'(R_LINE - BALL_SIZE);

    state_t     r_state, w_state_nxt;
    pos_t       r_x, w_x_nxt;
    pos_t       r_y, w_y_nxt;
    logic       r_dx, w_dx_nxt;
    logic       r_dy, w_dy_nxt;
    speed_t     r_speed, w_speed_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic       r_hit, w_hit_nxt;
    logic       r_score_l, w_score_l_nxt;
    logic       r_score_r, w_score_r_nxt;

    spos_t w_nx;
    pos_t  w_y_step;
    logic  w_dy_step;
    logic  w_zone_l, w_zone_r, w_out_l, w_out_r, w_cover_l, w_cover_r;

    ball_axis_step #(.LIMIT(HEIGHT)) u_y_step (
        .i_pos     (r_y),
        .i_dir_pos (r_dy),
        .i_speed   (r_speed),
        .o_pos     (w_y_step),
        .o_dir_pos (w_dy_step)
    );

    assign w_nx      = axis_step(r_x, r_dx, r_speed);
    assign w_zone_l  = !r_dx && (w_nx - BALL_SIZE <= L_LINE);
    assign w_zone_r  = r_dx && (w_nx + BALL_SIZE >= R_LINE);
    assign w_out_l   = (w_nx - BALL_SIZE <= SZERO);
    assign w_out_r   = (w_nx + BALL_SIZE >= WIDTH);
    // Paddle overlap is judged on the row the ball occupies before this frame's step.
    assign w_cover_l = paddle_covers(r_y, paddle_l_y);
    assign w_cover_r = paddle_covers(r_y, paddle_r_y);

    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_dx_nxt      = r_dx;
        w_dy_nxt      = r_dy;
        w_speed_nxt   = r_speed;
        w_cnt_nxt     = r_cnt;
        w_hit_nxt     = 1'b0;
        w_score_l_nxt = 1'b0;
        w_score_r_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_x_nxt = CENTRE_X;
                w_y_nxt = CENTRE_Y;
                if (serve) begin
                    w_state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (frame_tick) begin
                    w_x_nxt  = w_nx[POS_W-1:0];
                    w_y_nxt  = w_y_step;
                    w_dy_nxt = w_dy_step;
                    if (w_zone_l && w_cover_l) begin
                        w_x_nxt   = X_BOUNCE_L;
                        w_dx_nxt  = 1'b1;
                        w_hit_nxt = 1'b1;
                    end else if (w_zone_l && w_out_l) begin
                        w_score_r_nxt = 1'b1;
                        w_dx_nxt      = 1'b0;
                    end else if (w_zone_r && w_cover_r) begin
                        w_x_nxt   = X_BOUNCE_R;
                        w_dx_nxt  = 1'b0;
                        w_hit_nxt = 1'b1;
                    end else if (w_zone_r && w_out_r) begin
                        w_score_l_nxt = 1'b1;
                        w_dx_nxt      = 1'b1;
                    end
`ifdef BALL_SPEEDUP_EN
                    if (w_hit_nxt && (r_speed < SPEED_MAX)) begin
                        w_speed_nxt = r_speed + 4'd1;
                    end
`endif
                    if (w_score_l_nxt || w_score_r_nxt) begin
                        w_x_nxt     = CENTRE_X;
                        w_y_nxt     = CENTRE_Y;
                        w_speed_nxt = SPEED_INIT;
                        w_cnt_nxt   = PAUSE_FRAMES - 6'd1;
                        w_state_nxt = PAUSE;
                    end
                end
            end
            PAUSE: begin
                w_x_nxt = CENTRE_X;
                w_y_nxt = CENTRE_Y;
                if (frame_tick) begin
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= CENTRE_X;
            r_y       <= CENTRE_Y;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_speed   <= SPEED_INIT;
            r_cnt     <= 6'd0;
            r_hit     <= 1'b0;
            r_score_l <= 1'b0;
            r_score_r <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_dx      <= w_dx_nxt;
            r_dy      <= w_dy_nxt;
            r_speed   <= w_speed_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hit     <= w_hit_nxt;
            r_score_l <= w_score_l_nxt;
            r_score_r <= w_score_r_nxt;
        end
    end

    assign ball_x  = r_x;
    assign ball_y  = r_y;
    assign hit     = r_hit;
    assign score_l = r_score_l;
    assign score_r = r_score_r;
    assign in_play = (r_state == MOVE);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: one long rally with hand-computed checkpoints per frame.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        serve;
    logic [10:0] paddle_l_y;
    logic [10:0] paddle_r_y;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic        hit;
    logic        score_l;
    logic        score_r;
    logic        in_play;

    int n_tests = 0;
    int n_fail  = 0;
    int frame   = 0;

    ball_motion dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .serve      (serve),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit        (hit),
        .score_l    (score_l),
        .score_r    (score_r),
        .in_play    (in_play)
    );

    always #5 clk = ~clk;

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            clk1();
            frame_tick = 1'b0;
            clk1();
        end
        frame += n;
    endtask

    task automatic goto_frame(input int t);
        run_frames(t - frame);
    endtask

    task automatic tick_once;
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        frame++;
    endtask

    task automatic test_reset;
        rst = 1'b1; serve = 1'b0; frame_tick = 1'b0;
        paddle_l_y = 11'd240; paddle_r_y = 11'd240;
        clk1(); clk1();
        rst = 1'b0;
        n_tests++;
        if ({ball_x, ball_y} !== {11'd319, 11'd239}) begin
            n_fail++; $display("FAIL reset_pos: got (%0d,%0d) want (319,239)", ball_x, ball_y);
        end
        n_tests++;
        if ({hit, score_l, score_r, in_play} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {hit, score_l, score_r, in_play});
        end
        tick_once();
        clk1();
        n_tests++;
        if ({in_play, ball_x, ball_y} !== {1'b0, 11'd319, 11'd239}) begin
            n_fail++; $display("FAIL idle_tick: got in_play=%0d (%0d,%0d) want 0 (319,239)", in_play, ball_x, ball_y);
        end
    endtask

    task automatic test_serve;
        serve = 1'b1; frame_tick = 1'b1;
        clk1();
        serve = 1'b0; frame_tick = 1'b0;
        frame = 0;
        n_tests++;
        if ({in_play, ball_x, ball_y} !== {1'b1, 11'd319, 11'd239}) begin
            n_fail++; $display("FAIL serve_launch: got in_play=%0d (%0d,%0d) want 1 (319,239)", in_play, ball_x, ball_y);
        end
        tick_once();
        n_tests++;
        if ({in_play, ball_x, ball_y} !== {1'b1, 11'd321, 11'd241}) begin
            n_fail++; $display("FAIL serve_first_step: got in_play=%0d (%0d,%0d) want 1 (321,241)", in_play, ball_x, ball_y);
        end
    endtask

    task automatic test_bottom_wall;
        goto_frame(118);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd555, 11'd475}) begin
            n_fail++; $display("FAIL bwall_before: got (%0d,%0d) want (555,475)", ball_x, ball_y);
        end
        tick_once();
        n_tests++;
        if ({ball_x, ball_y, hit, score_l, score_r} !== {11'd557, 11'd476, 3'b000}) begin
            n_fail++; $display("FAIL bwall_clamp: got (%0d,%0d) pulses %b want (557,476) 000", ball_x, ball_y, {hit, score_l, score_r});
        end
        clk1();
        goto_frame(120);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd559, 11'd474}) begin
            n_fail++; $display("FAIL bwall_after: got (%0d,%0d) want (559,474)", ball_x, ball_y);
        end
    endtask

    task automatic test_paddle_right;
        paddle_r_y = 11'd455;
        goto_frame(146);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd611, 11'd422}) begin
            n_fail++; $display("FAIL rpad_before: got (%0d,%0d) want (611,422)", ball_x, ball_y);
        end
        tick_once();
        n_tests++;
        if ({ball_x, ball_y, hit, score_l, score_r} !== {11'd613, 11'd420, 3'b100}) begin
            n_fail++; $display("FAIL rpad_hit: got (%0d,%0d) pulses %b want (613,420) 100", ball_x, ball_y, {hit, score_l, score_r});
        end
        clk1();
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL rpad_hit_width: got hit=%0d want 0", hit);
        end
    endtask

    task automatic test_top_wall;
        goto_frame(355);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd197, 11'd4}) begin
            n_fail++; $display("FAIL twall_before: got (%0d,%0d) want (197,4)", ball_x, ball_y);
        end
        goto_frame(356);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd195, 11'd3}) begin
            n_fail++; $display("FAIL twall_clamp: got (%0d,%0d) want (195,3)", ball_x, ball_y);
        end
        goto_frame(357);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd193, 11'd5}) begin
            n_fail++; $display("FAIL twall_after: got (%0d,%0d) want (193,5)", ball_x, ball_y);
        end
    endtask

    task automatic test_paddle_left;
        paddle_l_y = 11'd138;
        goto_frame(440);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd27, 11'd171}) begin
            n_fail++; $display("FAIL lpad_before: got (%0d,%0d) want (27,171)", ball_x, ball_y);
        end
        tick_once();
        n_tests++;
        if ({ball_x, ball_y, hit, score_l, score_r} !== {11'd26, 11'd173, 3'b100}) begin
            n_fail++; $display("FAIL lpad_hit_edge: got (%0d,%0d) pulses %b want (26,173) 100", ball_x, ball_y, {hit, score_l, score_r});
        end
        clk1();
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL lpad_hit_width: got hit=%0d want 0", hit);
        end
        goto_frame(442);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd28, 11'd175}) begin
            n_fail++; $display("FAIL lpad_after: got (%0d,%0d) want (28,175)", ball_x, ball_y);
        end
    endtask

    task automatic test_score_l;
        paddle_r_y = 11'd1000;
        goto_frame(593);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd330, 11'd476}) begin
            n_fail++; $display("FAIL scl_wall: got (%0d,%0d) want (330,476)", ball_x, ball_y);
        end
        goto_frame(735);
        n_tests++;
        if ({ball_x, ball_y, hit, score_l} !== {11'd614, 11'd192, 2'b00}) begin
            n_fail++; $display("FAIL scl_pass_line: got (%0d,%0d) hit=%0d score_l=%0d want (614,192) 0 0", ball_x, ball_y, hit, score_l);
        end
        goto_frame(745);
        n_tests++;
        if ({ball_x, ball_y, score_l} !== {11'd634, 11'd172, 1'b0}) begin
            n_fail++; $display("FAIL scl_before: got (%0d,%0d) score_l=%0d want (634,172) 0", ball_x, ball_y, score_l);
        end
        tick_once();
        n_tests++;
        if ({ball_x, ball_y, hit, score_l, score_r, in_play} !== {11'd319, 11'd239, 4'b0100}) begin
            n_fail++; $display("FAIL scl_pulse: got (%0d,%0d) flags %b want (319,239) 0100", ball_x, ball_y, {hit, score_l, score_r, in_play});
        end
        clk1();
        n_tests++;
        if (score_l !== 1'b0) begin
            n_fail++; $display("FAIL scl_width: got score_l=%0d want 0", score_l);
        end
    endtask

    task automatic test_pause;
        run_frames(59);
        serve = 1'b1;
        clk1();
        serve = 1'b0;
        n_tests++;
        if ({in_play, ball_x, ball_y} !== {1'b0, 11'd319, 11'd239}) begin
            n_fail++; $display("FAIL pause_59: got in_play=%0d (%0d,%0d) want 0 (319,239)", in_play, ball_x, ball_y);
        end
        tick_once();
        clk1();
        serve = 1'b1;
        clk1();
        serve = 1'b0;
        frame = 0;
        n_tests++;
        if (in_play !== 1'b1) begin
            n_fail++; $display("FAIL pause_60_serve: got in_play=%0d want 1", in_play);
        end
        tick_once();
        n_tests++;
        if ({ball_x, ball_y} !== {11'd321, 11'd237}) begin
            n_fail++; $display("FAIL reserve_after_l: got (%0d,%0d) want (321,237)", ball_x, ball_y);
        end
    endtask

    task automatic test_score_r;
        paddle_r_y = 11'd59;
        goto_frame(146);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd611, 11'd59}) begin
            n_fail++; $display("FAIL scr_rpad_before: got (%0d,%0d) want (611,59)", ball_x, ball_y);
        end
        goto_frame(147);
        paddle_l_y = 11'd1000;
        goto_frame(441);
        n_tests++;
        if ({ball_x, ball_y, score_r} !== {11'd25, 11'd304, 1'b0}) begin
            n_fail++; $display("FAIL scr_pass_line: got (%0d,%0d) score_r=%0d want (25,304) 0", ball_x, ball_y, score_r);
        end
        goto_frame(451);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd5, 11'd284}) begin
            n_fail++; $display("FAIL scr_before: got (%0d,%0d) want (5,284)", ball_x, ball_y);
        end
        tick_once();
        n_tests++;
        if ({ball_x, ball_y, hit, score_l, score_r, in_play} !== {11'd319, 11'd239, 4'b0010}) begin
            n_fail++; $display("FAIL scr_pulse: got (%0d,%0d) flags %b want (319,239) 0010", ball_x, ball_y, {hit, score_l, score_r, in_play});
        end
        clk1();
        run_frames(60);
        serve = 1'b1;
        clk1();
        serve = 1'b0;
        frame = 0;
        tick_once();
        n_tests++;
        if ({in_play, ball_x, ball_y} !== {1'b1, 11'd317, 11'd237}) begin
            n_fail++; $display("FAIL reserve_after_r: got in_play=%0d (%0d,%0d) want 1 (317,237)", in_play, ball_x, ball_y);
        end
    endtask

`ifdef BALL_SPEEDUP_EN
    task automatic test_speedup;
        paddle_r_y = 11'd455;
        goto_frame(147);
        n_tests++;
        if ({ball_x, ball_y, hit} !== {11'd613, 11'd420, 1'b1}) begin
            n_fail++; $display("FAIL spd_hit: got (%0d,%0d) hit=%0d want (613,420) 1", ball_x, ball_y, hit);
        end
        goto_frame(148);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd610, 11'd417}) begin
            n_fail++; $display("FAIL spd_step3: got (%0d,%0d) want (610,417)", ball_x, ball_y);
        end
        paddle_l_y = 11'd1000;
        goto_frame(286);
        n_tests++;
        if ({ball_x, ball_y} !== {11'd196, 11'd3}) begin
            n_fail++; $display("FAIL spd_twall: got (%0d,%0d) want (196,3)", ball_x, ball_y);
        end
        goto_frame(350);
        tick_once();
        n_tests++;
        if ({ball_x, ball_y, score_r} !== {11'd319, 11'd239, 1'b1}) begin
            n_fail++; $display("FAIL spd_score: got (%0d,%0d) score_r=%0d want (319,239) 1", ball_x, ball_y, score_r);
        end
        clk1();
        run_frames(60);
        serve = 1'b1;
        clk1();
        serve = 1'b0;
        frame = 0;
        tick_once();
        n_tests++;
        if ({ball_x, ball_y} !== {11'd317, 11'd241}) begin
            n_fail++; $display("FAIL spd_restored: got (%0d,%0d) want (317,241)", ball_x, ball_y);
        end
    endtask
`endif

    task automatic test_reset_mid_move;
        run_frames(3);
        rst = 1'b1; frame_tick = 1'b1;
        clk1();
        rst = 1'b0; frame_tick = 1'b0;
        n_tests++;
        if ({ball_x, ball_y, hit, score_l, score_r, in_play} !== {11'd319, 11'd239, 4'b0000}) begin
            n_fail++; $display("FAIL midrst: got (%0d,%0d) flags %b want (319,239) 0000", ball_x, ball_y, {hit, score_l, score_r, in_play});
        end
        serve = 1'b1;
        clk1();
        serve = 1'b0;
        tick_once();
        n_tests++;
        if ({ball_x, ball_y} !== {11'd321, 11'd241}) begin
            n_fail++; $display("FAIL midrst_dirs: got (%0d,%0d) want (321,241)", ball_x, ball_y);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_serve();
        test_bottom_wall();
`ifdef BALL_SPEEDUP_EN
        test_speedup();
`else
        test_paddle_right();
        test_top_wall();
        test_paddle_left();
        test_score_l();
        test_pause();
        test_score_r();
`endif
        test_reset_mid_move();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
